ddr_access_arbiter: RTL and testbench
=====================================

Name: ddr_access_arbiter

Overview:
Shares the single DDR single-word command interface between two requesters: the video line prefetcher (read-only, high priority) and the cellular-automaton engine (read/write, low priority). It sequences one transaction at a time through a req/ack/done handshake, routes read data and completion back to the owner, and bounds starvation of the low-priority port. It sits between the display/compute blocks and the DDR controller, in the 133 MHz controller clock domain.

Parameters:
ADDR_W, 23, word address width
DATA_W, 16, data width
STARVE_LIMIT, 4, consecutive video grants allowed while engine waits (1..15)
TIMEOUT, 255, max cycles in WAIT_DONE before abort (1..255)

Ports:
clk  in  1  controller clock
rst  in  1  synchronous active-high reset
vidReq  in  1  video read request, held until vidDone
vidAddr  in  ADDR_W  video read address
vidGrant  out  1  video owns memory port
vidDone  out  1  one-cycle completion pulse
vidRData  out  DATA_W  read data, valid with vidDone
golReq  in  1  engine request, held until golDone
golWe  in  1  1=write, 0=read
golAddr  in  ADDR_W  engine address
golWData  in  DATA_W  engine write data
golGrant  out  1  engine owns memory port
golDone  out  1  one-cycle completion pulse
golRData  out  DATA_W  read data, valid with golDone
memReq  out  1  command valid to DDR controller
memWe  out  1  command write enable
memAddr  out  ADDR_W  command address
memWData  out  DATA_W  command write data
memAck  in  1  controller accepted command
memDone  in  1  transaction complete
memRData  in  DATA_W  read data, valid with memDone
timeoutErr  out  1  sticky, set on any timeout

Behaviour:
- Reset: state IDLE; all outputs 0 (grants, dones, memReq, memWe, memAddr, memWData, rdata regs, timeoutErr); starveCnt=0, timer=0.
- FSM: IDLE -> ISSUE -> WAIT_DONE -> IDLE.
- IDLE: if no request, stay. Else pick owner: engine if golReq && (!vidReq || starveCnt>=STARVE_LIMIT), otherwise video. Register owner's addr/we/wdata onto mem* (video: memWe=0, memWData=0). Next cycle: ISSUE, memReq=1, owner grant=1.
- starveCnt: +1 (saturating at 15) on each video grant taken while golReq=1; cleared on engine grant; unchanged otherwise.
- ISSUE: hold memReq and command stable until memAck=1. Cycle after memAck: memReq=0, state WAIT_DONE, timer=0. memDone in the same cycle as memAck is treated as completion (skip WAIT_DONE).
- WAIT_DONE: on memDone, latch memRData into owner's rdata (reads only; writes leave rdata unchanged), pulse owner's done 1 cycle, drop grant, go IDLE. Minimum turnaround: done pulse cycle is the IDLE cycle; new arbitration occurs the cycle after done.
- Timeout: timer increments each WAIT_DONE cycle; at timer==TIMEOUT without memDone -> set timeoutErr, pulse owner's done (rdata unchanged), go IDLE.
- Requester dropping req mid-transaction: transaction still completes; done pulse still issued.
- memAck/memDone outside ISSUE/WAIT_DONE: ignored.
- Grants mutually exclusive; at most one done pulse per cycle.
- rst asserted mid-transaction: immediate return to reset state next edge; no done pulse.

Test Plan:
- Single video read addr 0x000100, controller acks after 2 cycles, memDone after 5 with 0xBEEF -> memReq high 3 cycles, vidGrant high through completion, vidDone 1 cycle, vidRData=0xBEEF.
- Engine write addr 0x7FFFFF data 0x1234 -> memWe=1, memAddr=0x7FFFFF, memWData=0x1234; golDone pulse; golRData stays 0.
- Both request continuously, STARVE_LIMIT=4 -> grant order V,V,V,V,G,V,V,V,V,G; starveCnt returns to 0 after each G.
- Simultaneous first requests with starveCnt=0 -> video granted first; engine granted next, no idle gap beyond one arbitration cycle.
- Controller never asserts memDone, TIMEOUT=255 -> after 255 WAIT_DONE cycles timeoutErr=1 (sticky), owner done pulse, next request serviced normally.
- rst pulsed while in WAIT_DONE -> all outputs 0 next cycle, no done pulse, timeoutErr cleared.

Source files
------------

// File: rtl/ddr_access_arbiter_if.sv
// Requester, engine and DDR-controller signals shared by the access arbiter.
// The slave modport is the arbiter's view; master is the surrounding logic's view.
interface ddr_access_arbiter_if #(
    parameter int ADDR_W = 23,
    parameter int DATA_W = 16
);
    logic              vidReq;
    logic [ADDR_W-1:0] vidAddr;
    logic              vidGrant;
    logic              vidDone;
    logic [DATA_W-1:0] vidRData;

    logic              golReq;
    logic              golWe;
    logic [ADDR_W-1:0] golAddr;
    logic [DATA_W-1:0] golWData;
    logic              golGrant;
    logic              golDone;
    logic [DATA_W-1:0] golRData;

    logic              memReq;
    logic              memWe;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memWData;
    logic              memAck;
    logic              memDone;
    logic [DATA_W-1:0] memRData;

    logic              timeoutErr;

    modport slave (
        input  vidReq, vidAddr, golReq, golWe, golAddr, golWData,
               memAck, memDone, memRData,
        output vidGrant, vidDone, vidRData, golGrant, golDone, golRData,
               memReq, memWe, memAddr, memWData, timeoutErr
    );

    modport master (
        output vidReq, vidAddr, golReq, golWe, golAddr, golWData,
               memAck, memDone, memRData,
        input  vidGrant, vidDone, vidRData, golGrant, golDone, golRData,
               memReq, memWe, memAddr, memWData, timeoutErr
    );
endinterface

// File: rtl/ddr_access_arbiter.sv
// Two-requester DDR single-word command arbiter: video reads win unless the engine
// has waited STARVE_LIMIT video grants; one transaction in flight with a done timeout.
module ddr_access_arbiter #(
    parameter int ADDR_W       = 23,
    parameter int DATA_W       = 16,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic                clk,
    input  logic                rst,
    ddr_access_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic              owner_q, owner_d;      // 1 = engine owns the port
    cmd_t              cmd_q, cmd_d;
    logic              memReq_q, memReq_d;
    logic              vidGrant_q, vidGrant_d;
    logic              golGrant_q, golGrant_d;
    logic              vidDone_q, vidDone_d;
    logic              golDone_q, golDone_d;
    logic [DATA_W-1:0] vidRData_q, vidRData_d;
    logic [DATA_W-1:0] golRData_q, golRData_d;
    logic              timeoutErr_q, timeoutErr_d;
    logic [3:0]        starveCnt_q, starveCnt_d;
    logic [7:0]        timer_q, timer_d;

    logic              pickGol;
    logic              complete;
    logic              abort;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            cmd_q        <= '0;
            memReq_q     <= 1'b0;
            vidGrant_q   <= 1'b0;
            golGrant_q   <= 1'b0;
            vidDone_q    <= 1'b0;
            golDone_q    <= 1'b0;
            vidRData_q   <= '0;
            golRData_q   <= '0;
            timeoutErr_q <= 1'b0;
            starveCnt_q  <= '0;
            timer_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            cmd_q        <= cmd_d;
            memReq_q     <= memReq_d;
            vidGrant_q   <= vidGrant_d;
            golGrant_q   <= golGrant_d;
            vidDone_q    <= vidDone_d;
            golDone_q    <= golDone_d;
            vidRData_q   <= vidRData_d;
            golRData_q   <= golRData_d;
            timeoutErr_q <= timeoutErr_d;
            starveCnt_q  <= starveCnt_d;
            timer_q      <= timer_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        cmd_d        = cmd_q;
        memReq_d     = memReq_q;
        vidGrant_d   = vidGrant_q;
        golGrant_d   = golGrant_q;
        vidDone_d    = 1'b0;
        golDone_d    = 1'b0;
        vidRData_d   = vidRData_q;
        golRData_d   = golRData_q;
        timeoutErr_d = timeoutErr_q;
        starveCnt_d  = starveCnt_q;
        timer_d      = timer_q;
        pickGol      = 1'b0;
        complete     = 1'b0;
        abort        = 1'b0;

        unique case (state_q)
            IDLE: begin
                // The done-pulse cycle is skipped so a still-held request is not re-served.
                if (!(vidDone_q || golDone_q) && (bus.vidReq || bus.golReq)) begin
                    pickGol  = bus.golReq && (!bus.vidReq || starveCnt_q >= STARVE_MAX);
                    owner_d  = pickGol;
                    state_d  = ISSUE;
                    memReq_d = 1'b1;
                    if (pickGol) begin
                        cmd_d       = '{we: bus.golWe, addr: bus.golAddr, wdata: bus.golWData};
                        golGrant_d  = 1'b1;
                        starveCnt_d = '0;
                    end else begin
                        cmd_d      = '{we: 1'b0, addr: bus.vidAddr, wdata: '0};
                        vidGrant_d = 1'b1;
                        if (bus.golReq && starveCnt_q != 4'hF)
                            starveCnt_d = starveCnt_q + 4'd1;
                    end
                end
            end
            ISSUE: begin
                if (bus.memAck) begin
                    memReq_d = 1'b0;
                    if (bus.memDone) begin
                        complete = 1'b1;
                    end else begin
                        state_d = WAIT_DONE;
                        timer_d = '0;
                    end
                end
            end
            WAIT_DONE: begin
                if (bus.memDone)
                    complete = 1'b1;
                else if (timer_q == TMO_LAST)
                    abort = 1'b1;
                else
                    timer_d = timer_q + 8'd1;
            end
            default: state_d = IDLE;
        endcase

        if (complete || abort) begin
            state_d    = IDLE;
            memReq_d   = 1'b0;
            vidGrant_d = 1'b0;
            golGrant_d = 1'b0;
            vidDone_d  = !owner_q;
            golDone_d  = owner_q;
            if (abort)
                timeoutErr_d = 1'b1;
            else if (!cmd_q.we) begin
                if (owner_q) golRData_d = bus.memRData;
                else         vidRData_d = bus.memRData;
            end
        end
    end

    assign bus.vidGrant   = vidGrant_q;
    assign bus.vidDone    = vidDone_q;
    assign bus.vidRData   = vidRData_q;
    assign bus.golGrant   = golGrant_q;
    assign bus.golDone    = golDone_q;
    assign bus.golRData   = golRData_q;
    assign bus.memReq     = memReq_q;
    assign bus.memWe      = cmd_q.we;
    assign bus.memAddr    = cmd_q.addr;
    assign bus.memWData   = cmd_q.wdata;
    assign bus.timeoutErr = timeoutErr_q;

endmodule

// File: tb/tb_ddr_access_arbiter.sv
// Directed and randomized bench for ddr_access_arbiter; the DDR controller is played
// inline and results are compared against a transaction-level model.
module tb_ddr_access_arbiter;
    localparam int ADDR_W       = 23;
    localparam int DATA_W       = 16;
    localparam int STARVE_LIMIT = 4;
    localparam int TIMEOUT      = 255;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #4 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Transaction-level reference state
    int          mStarve = 0;
    logic [15:0] mVidRd  = '0;
    logic [15:0] mGolRd  = '0;
    logic        mErr    = 1'b0;

    logic        gg;
    int          lat;
    logic [9:0]  order;
    logic        quiet;
    logic [1:0]  rr;

    ddr_access_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ddr_access_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, 32'({bus.vidGrant, bus.golGrant, bus.vidDone, bus.golDone,
                                bus.memReq, bus.memWe, bus.timeoutErr}), 0);
        chk({tag, "_addr"},  32'(bus.memAddr), 0);
        chk({tag, "_wdata"}, 32'(bus.memWData), 0);
        chk({tag, "_rdata"}, {bus.vidRData, bus.golRData}, 0);
    endtask

    // Play one transaction as the DDR controller. Called at a negedge with the
    // arbiter idle; returns at the negedge following the done pulse.
    task automatic txn(input int ackDly, input int doneDly, input bit noDone, input bit dropMid,
                       input logic [15:0] rd, output logic gotGol, output int latency);
        logic              expGol, eWe, early, held;
        logic [ADDR_W-1:0] eAddr;
        logic [DATA_W-1:0] eWData;
        int                reqCnt, n;

        expGol = bus.golReq && (!bus.vidReq || mStarve >= STARVE_LIMIT);
        if (expGol) mStarve = 0;
        else if (bus.golReq && mStarve < 15) mStarve++;
        eWe    = expGol && bus.golWe;
        eAddr  = expGol ? bus.golAddr : bus.vidAddr;
        eWData = expGol ? bus.golWData : '0;
        gotGol = 1'b0;

        latency = 0;
        while (bus.memReq !== 1'b1 && latency < 8) begin
            @(negedge clk);
            latency++;
        end
        chk("mem_req_seen", 32'(bus.memReq), 1);
        if (bus.memReq !== 1'b1) return;
        chk("arb_latency", latency, 1);

        gotGol = bus.golGrant;
        chk("grant_vid", 32'(bus.vidGrant), 32'(!expGol));
        chk("grant_gol", 32'(bus.golGrant), 32'(expGol));
        chk("cmd_we",    32'(bus.memWe), 32'(eWe));
        chk("cmd_addr",  32'(bus.memAddr), 32'(eAddr));
        chk("cmd_wdata", 32'(bus.memWData), 32'(eWData));

        reqCnt = 0;
        held   = 1'b1;
        for (int k = 0; k <= ackDly; k++) begin
            reqCnt += int'(bus.memReq);
            held &= (bus.memAddr === eAddr) && (bus.memWe === eWe) && (bus.memWData === eWData)
                    && (bus.vidGrant === !expGol) && (bus.golGrant === expGol)
                    && !bus.vidDone && !bus.golDone;
            if (k == ackDly) begin
                bus.memAck = 1'b1;
                if (doneDly == 0 && !noDone) begin
                    bus.memDone  = 1'b1;
                    bus.memRData = rd;
                end
                if (dropMid) begin
                    if (expGol) bus.golReq = 1'b0;
                    else        bus.vidReq = 1'b0;
                end
            end
            @(negedge clk);
        end
        bus.memAck  = 1'b0;
        bus.memDone = 1'b0;
        chk("issue_cycles", reqCnt, ackDly + 1);
        chk("issue_stable", 32'(held), 1);
        chk("req_after_ack", 32'(bus.memReq), 0);

        if (noDone || doneDly > 0) begin
            n     = noDone ? TIMEOUT : doneDly;
            early = 1'b0;
            for (int k = 1; k <= n; k++) begin
                early |= bus.vidDone | bus.golDone | bus.memReq
                         | (bus.vidGrant !== !expGol) | (bus.golGrant !== expGol);
                if (!noDone && k == n) begin
                    bus.memDone  = 1'b1;
                    bus.memRData = rd;
                end
                @(negedge clk);
            end
            bus.memDone = 1'b0;
            chk("wait_quiet", 32'(early), 0);
        end

        if (noDone) mErr = 1'b1;
        else if (!eWe) begin
            if (expGol) mGolRd = rd;
            else        mVidRd = rd;
        end
        chk("done_vid", 32'(bus.vidDone), 32'(!expGol));
        chk("done_gol", 32'(bus.golDone), 32'(expGol));
        chk("grant_released", 32'({bus.vidGrant, bus.golGrant}), 0);
        chk("rdata_vid", 32'(bus.vidRData), 32'(mVidRd));
        chk("rdata_gol", 32'(bus.golRData), 32'(mGolRd));
        chk("timeout_err", 32'(bus.timeoutErr), 32'(mErr));

        @(negedge clk);
        chk("done_one_cycle", 32'({bus.vidDone, bus.golDone}), 0);
        chk("no_arb_in_done_cycle", 32'(bus.memReq), 0);
    endtask

    initial begin
        bus.vidReq = 1'b0; bus.vidAddr = '0;
        bus.golReq = 1'b0; bus.golWe = 1'b0; bus.golAddr = '0; bus.golWData = '0;
        bus.memAck = 1'b0; bus.memDone = 1'b0; bus.memRData = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Controller strobes while idle must be ignored
        bus.memAck = 1'b1; bus.memDone = 1'b1; bus.memRData = 16'hFFFF;
        @(negedge clk);
        bus.memAck = 1'b0; bus.memDone = 1'b0;
        chk("idle_strobe_ignored", 32'({bus.memReq, bus.vidDone, bus.golDone, bus.timeoutErr}), 0);
        chk("idle_strobe_rdata", {bus.vidRData, bus.golRData}, 0);

        // Single video read
        bus.vidAddr = 23'h000100; bus.vidReq = 1'b1;
        txn(2, 5, 0, 0, 16'hBEEF, gg, lat);
        chk("vid_rdata_beef", 32'(bus.vidRData), 32'h0000BEEF);
        bus.vidReq = 1'b0;

        // Engine write at the top address
        bus.golWe = 1'b1; bus.golAddr = 23'h7FFFFF; bus.golWData = 16'h1234; bus.golReq = 1'b1;
        txn(1, 3, 0, 0, 16'hDEAD, gg, lat);
        chk("gol_write_rdata_zero", 32'(bus.golRData), 0);
        bus.golReq = 1'b0;
        @(negedge clk);

        // Simultaneous first requests
        bus.golWe = 1'b0; bus.golAddr = 23'h001234;
        bus.vidAddr = 23'h000200;
        bus.vidReq = 1'b1; bus.golReq = 1'b1;
        txn(0, 2, 0, 0, 16'h5A5A, gg, lat);
        chk("simul_first_video", 32'(gg), 0);
        bus.vidReq = 1'b0;
        txn(0, 1, 0, 0, 16'hA5A5, gg, lat);
        chk("simul_then_engine", 32'(gg), 1);
        bus.golReq = 1'b0;
        @(negedge clk);

        // Both requesting continuously: starvation bound
        bus.vidReq = 1'b1; bus.golReq = 1'b1;
        order = '0;
        for (int i = 0; i < 10; i++) begin
            txn(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 0, 0,
                16'($urandom), gg, lat);
            order[i] = gg;
        end
        chk("grant_order", 32'(order), 32'h210);
        bus.vidReq = 1'b0; bus.golReq = 1'b0;
        @(negedge clk);

        // Controller never completes: timeout, then normal service
        bus.vidAddr = 23'h0ABCDE; bus.vidReq = 1'b1;
        txn(1, 0, 1, 0, 16'h0000, gg, lat);
        bus.vidReq = 1'b0;
        bus.golWe = 1'b0; bus.golAddr = 23'h00F00D; bus.golReq = 1'b1;
        txn(0, 2, 0, 0, 16'hC0DE, gg, lat);
        bus.golReq = 1'b0;
        chk("timeout_sticky", 32'(bus.timeoutErr), 1);

        // Randomized traffic
        for (int it = 0; it < 30; it++) begin
            rr = 2'($urandom_range(1, 3));
            bus.vidReq   = rr[0];
            bus.golReq   = rr[1];
            bus.vidAddr  = 23'($urandom);
            bus.golAddr  = 23'($urandom);
            bus.golWData = 16'($urandom);
            bus.golWe    = 1'($urandom);
            txn(int'($urandom_range(0, 3)), int'($urandom_range(0, 6)), 0,
                ($urandom_range(0, 3) == 0), 16'($urandom), gg, lat);
        end
        bus.vidReq = 1'b0; bus.golReq = 1'b0;
        @(negedge clk);

        // Reset while waiting for completion, with memDone racing the reset
        bus.vidAddr = 23'h000321; bus.vidReq = 1'b1;
        lat = 0;
        while (bus.memReq !== 1'b1 && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        chk("rst_test_req_seen", 32'(bus.memReq), 1);
        bus.memAck = 1'b1;
        @(negedge clk);
        bus.memAck = 1'b0;
        @(negedge clk);
        rst = 1'b1; bus.memDone = 1'b1; bus.memRData = 16'h7777;
        @(negedge clk);
        bus.memDone = 1'b0;
        chk_zero("mid_rst");
        rst = 1'b0; bus.vidReq = 1'b0;
        mStarve = 0; mVidRd = '0; mGolRd = '0; mErr = 1'b0;
        quiet = 1'b0;
        repeat (3) begin
            @(negedge clk);
            quiet |= bus.vidDone | bus.golDone | bus.memReq | bus.vidGrant | bus.golGrant;
        end
        chk("post_rst_quiet", 32'(quiet), 0);

        // Normal service after reset
        bus.golWe = 1'b0; bus.golAddr = 23'h000042; bus.golReq = 1'b1;
        txn(1, 1, 0, 0, 16'h4242, gg, lat);
        bus.golReq = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
